// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// axi4_lite_pkg : shared encodings and default widths for the AXI4-Lite master
// Rev 1.0
// ============================================================================
package axi4_lite_pkg;

    localparam int DEF_ADDRESS_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 256;
    localparam int DEF_TO_WIDTH       = 16;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_RADDR = 3'd1;
    localparam logic [2:0] ENC_RDATA = 3'd2;
    localparam logic [2:0] ENC_WRITE = 3'd3;
    localparam logic [2:0] ENC_WRESP = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_RADDR = ENC_RADDR,
        ST_RDATA = ENC_RDATA,
        ST_WRITE = ENC_WRITE,
        ST_WRESP = ENC_WRESP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_timeout_ctr.sv
`default_nettype none
// ============================================================================
// axi4_lite_timeout_ctr : clear/enable watchdog, expires at TIMEOUT_CYCLES-1
// Rev 1.0
// ============================================================================
module axi4_lite_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_WIDTH       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    // A zero TIMEOUT_CYCLES disables the watchdog entirely.
    localparam bit                  C_ENABLED = (TIMEOUT_CYCLES != 0);
    localparam int                  C_LIMIT_I = C_ENABLED ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [TO_WIDTH-1:0] C_LIMIT   = C_LIMIT_I[TO_WIDTH-1:0];

    logic [TO_WIDTH-1:0] r_count;

    assign o_expire = C_ENABLED && i_enable && (r_count == C_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
        end else if (C_ENABLED && i_enable && !o_expire) begin
            r_count <= r_count + TO_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_master_cmdq.sv
`default_nettype none
// ============================================================================
// axi4_lite_master_cmdq : single-outstanding command/response AXI4-Lite master
// Rev 1.0
// ============================================================================
module axi4_lite_master_cmdq
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_WIDTH       = DEF_TO_WIDTH
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY,
    output logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY
);

    state_t r_state, w_state_nxt;
    logic   r_aw_done, r_w_done, w_aw_done_nxt, w_w_done_nxt;
    logic   w_arvalid_nxt, w_rready_nxt, w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt;
    logic   w_accept, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic   w_wd_enable, w_wd_clear, w_expire;
    logic                  w_rsp_fire, w_rsp_write, w_rsp_timeout;
    logic [DATA_WIDTH-1:0] w_rsp_rdata;
    logic [1:0]            w_rsp_resp;

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_ready && cmd_valid;
    assign w_ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
    assign w_r_hs    = M_AXI_RVALID  && M_AXI_RREADY;
    assign w_aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs    = M_AXI_WVALID  && M_AXI_WREADY;
    assign w_b_hs    = M_AXI_BVALID  && M_AXI_BREADY;

    // Enable excludes the handshake cycle, so a handshake on expiry completes normally.
    assign w_wd_clear  = (r_state != ST_RDATA) && (r_state != ST_WRESP);
    assign w_wd_enable = ((r_state == ST_RDATA) && !w_r_hs) ||
                         ((r_state == ST_WRESP) && !w_b_hs);

    axi4_lite_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_WIDTH       (TO_WIDTH)
    ) u_timeout_ctr (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_arvalid_nxt = M_AXI_ARVALID;
        w_rready_nxt  = M_AXI_RREADY;
        w_awvalid_nxt = M_AXI_AWVALID;
        w_wvalid_nxt  = M_AXI_WVALID;
        w_bready_nxt  = M_AXI_BREADY;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_rsp_fire    = 1'b0;
        w_rsp_write   = 1'b0;
        w_rsp_rdata   = '0;
        w_rsp_resp    = AXI_RESP_OKAY;
        w_rsp_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        w_state_nxt   = ST_WRITE;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                    end else begin
                        w_state_nxt   = ST_RADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            ST_RADDR: begin
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (w_r_hs || w_expire) begin
                    w_rready_nxt  = 1'b0;
                    w_state_nxt   = ST_IDLE;
                    w_rsp_fire    = 1'b1;
                    w_rsp_rdata   = w_r_hs ? M_AXI_RDATA : '0;
                    w_rsp_resp    = w_r_hs ? M_AXI_RRESP : AXI_RESP_SLVERR;
                    w_rsp_timeout = !w_r_hs;
                end
            end
            ST_WRITE: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt  = ST_WRESP;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WRESP: begin
                if (w_b_hs || w_expire) begin
                    w_bready_nxt  = 1'b0;
                    w_state_nxt   = ST_IDLE;
                    w_rsp_fire    = 1'b1;
                    w_rsp_write   = 1'b1;
                    w_rsp_resp    = w_b_hs ? M_AXI_BRESP : AXI_RESP_SLVERR;
                    w_rsp_timeout = !w_b_hs;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state       <= ST_IDLE;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= AXI_RESP_OKAY;
            rsp_timeout   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_aw_done     <= w_aw_done_nxt;
            r_w_done      <= w_w_done_nxt;
            M_AXI_ARVALID <= w_arvalid_nxt;
            M_AXI_RREADY  <= w_rready_nxt;
            M_AXI_AWVALID <= w_awvalid_nxt;
            M_AXI_WVALID  <= w_wvalid_nxt;
            M_AXI_BREADY  <= w_bready_nxt;
            if (w_accept && !cmd_write) begin
                M_AXI_ARADDR <= cmd_addr;
            end
            if (w_accept && cmd_write) begin
                M_AXI_AWADDR <= cmd_addr;
                M_AXI_WDATA  <= cmd_wdata;
                M_AXI_WSTRB  <= cmd_wstrb;
            end
            rsp_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                rsp_write   <= w_rsp_write;
                rsp_rdata   <= w_rsp_rdata;
                rsp_resp    <= w_rsp_resp;
                rsp_timeout <= w_rsp_timeout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master_cmdq.sv
`default_nettype none
// ============================================================================
// tb_axi4_lite_master_cmdq : directed vectors with a response scoreboard
// Rev 1.0
// ============================================================================
module tb_axi4_lite_master_cmdq;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_write, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] ARADDR, AWADDR;
    logic          ARVALID, RREADY, AWVALID, WVALID, BREADY;
    logic          ARREADY = 1'b0, RVALID = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
    logic [DW-1:0] RDATA = '0, WDATA;
    logic [1:0]    RRESP = '0, BRESP = '0;
    logic [3:0]    WSTRB;

    always #5 ACLK = ~ACLK;

    axi4_lite_master_cmdq #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(16)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
    );

    typedef struct packed {
        logic          w;
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          t;
    } rsp_t;

    rsp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge ACLK) begin
        rsp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_write", rsp_write, e.w);
                chk("rsp_rdata", rsp_rdata, e.d);
                chk("rsp_resp", rsp_resp, e.r);
                chk("rsp_timeout", rsp_timeout, e.t);
            end
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        step();
        cmd_valid = 1'b0;
    endtask

    // r_at == 0 means the slave never answers; otherwise RVALID is shown on cycle r_at.
    task automatic rd_txn(input logic [AW-1:0] a, input int ar_at, input int r_at,
                          input logic [DW-1:0] d, input logic [1:0] rs);
        logic to;
        int   end_c;
        to    = (r_at == 0);
        end_c = to ? (ar_at + TO) : r_at;
        sb.push_back(rsp_t'{w: 1'b0, d: (to ? '0 : d), r: (to ? 2'b10 : rs), t: to});
        issue(1'b0, a, '0, 4'h0);
        chk("rd_araddr", ARADDR, a);
        for (int c = 1; c <= end_c; c++) begin
            ARREADY = (c >= ar_at);
            RVALID  = (c == r_at);
            RDATA   = d;
            RRESP   = rs;
            chk("rd_arvalid", ARVALID, (c <= ar_at));
            chk("rd_rready", RREADY, (c > ar_at));
            chk("rd_no_early_rsp", rsp_valid, 0);
            step();
        end
        ARREADY = 1'b0; RVALID = 1'b0;
        chk("rd_rready_dropped", RREADY, 0);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_cmd_ready", cmd_ready, 1);
        step();
    endtask

    task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int aw_at, input int w_at, input logic [1:0] br);
        int last;
        last = (aw_at > w_at) ? aw_at : w_at;
        sb.push_back(rsp_t'{w: 1'b1, d: '0, r: br, t: 1'b0});
        issue(1'b1, a, d, s);
        chk("wr_awaddr", AWADDR, a);
        for (int c = 1; c <= last; c++) begin
            AWREADY = (c >= aw_at);
            WREADY  = (c >= w_at);
            chk("wr_awvalid", AWVALID, (c <= aw_at));
            chk("wr_wvalid", WVALID, (c <= w_at));
            chk("wr_bready_early", BREADY, 0);
            if (c == w_at) begin
                chk("wr_wstrb", WSTRB, s);
                chk("wr_wdata", WDATA, d);
            end
            step();
        end
        AWREADY = 1'b0; WREADY = 1'b0;
        chk("wr_bready", BREADY, 1);
        chk("wr_valids_low", {AWVALID, WVALID}, 2'b00);
        BVALID = 1'b1; BRESP = br;
        step();
        BVALID = 1'b0;
        chk("wr_rsp_valid", rsp_valid, 1);
        step();
    endtask

    initial begin
        repeat (2) step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_axi_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 5'b0);
        chk("rst_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout}, '0);
        ARESETN = 1'b1;
        step();

        // Best-case read: ARVALID cycle 1, rsp_valid cycle 3.
        rd_txn(32'h0000_0040, 1, 2, 32'hDEAD_BEEF, 2'b00);
        chk("rsp_pulse_one_cycle", rsp_valid, 0);
        chk("rsp_rdata_held", rsp_rdata, 32'hDEAD_BEEF);

        // AW delayed three cycles, W immediate.
        wr_txn(32'h0000_0010, 32'h1234_5678, 4'b0011, 3, 1, 2'b00);
        // W before AW, DECERR response.
        wr_txn(32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 2, 1, 2'b11);
        // AW before W, EXOKAY response.
        wr_txn(32'h0000_0024, 32'h0BAD_CAFE, 4'b1100, 1, 2, 2'b01);
        // Simultaneous handshakes: best-case write latency of 3.
        wr_txn(32'h0000_0028, 32'h5555_AAAA, 4'b0101, 1, 1, 2'b00);

        // Slave never answers: watchdog forces SLVERR completion.
        rd_txn(32'h0000_0080, 2, 0, 32'h1111_2222, 2'b00);
        // RVALID on the expiry cycle: handshake wins.
        rd_txn(32'h0000_0084, 1, 1 + TO, 32'hA5A5_0F0F, 2'b01);

        // Reset while waiting for BVALID abandons the write silently.
        AWREADY = 1'b1; WREADY = 1'b1;
        issue(1'b1, 32'h0000_0030, 32'hFFFF_0000, 4'b1111);
        step();
        AWREADY = 1'b0; WREADY = 1'b0;
        chk("rstmid_in_wresp", BREADY, 1);
        ARESETN = 1'b0;
        step();
        ARESETN = 1'b1;
        chk("rstmid_axi_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 5'b0);
        chk("rstmid_axi_payload", {AWADDR, WDATA, WSTRB}, '0);
        chk("rstmid_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout}, '0);
        chk("rstmid_cmd_ready", cmd_ready, 1);
        step();
        rd_txn(32'h0000_0090, 1, 2, 32'h0BAD_F00D, 2'b00);

        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_lite_master_cmdq.md
Name: axi4_lite_master_cmdq

Overview:
Parametrised AXI4-Lite master that turns a simple command/response interface into AXI4-Lite read and write transactions. It adds per-transfer byte strobes, independent AW/W handshakes, a registered response capture (data, RRESP/BRESP), and a response-phase timeout watchdog. It sits between a local controller (CPU stub, DMA sequencer) and the AXI4-Lite interconnect, one outstanding transaction at a time.

Parameters:
ADDRESS_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; must be 32 or 64
TIMEOUT_CYCLES, 256, cycles to wait in a response phase before forced completion; 0 disables the watchdog
TO_WIDTH, 16, timeout counter width; must satisfy TIMEOUT_CYCLES < 2^TO_WIDTH

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  reset; one clock, reset is synchronous and active-low
cmd_valid  in  1  command request
cmd_ready  out  1  master idle, command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDRESS_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  one-cycle completion pulse
rsp_write  out  1  completed command was a write
rsp_rdata  out  DATA_WIDTH  captured RDATA; 0 for writes and timeouts
rsp_resp  out  2  captured RRESP/BRESP; 2'b10 on timeout
rsp_timeout  out  1  completion forced by watchdog
M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY, M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY: standard AXI4-Lite master-side widths and directions

Behaviour:
- Reset (ARESETN low at a clock edge): state IDLE; all M_AXI_* outputs 0; cmd_ready 1; rsp_* 0; timeout counter 0. Reset mid-transaction abandons it without emitting rsp_valid.
- All AXI outputs are registered. Address, data and strobe are latched at command acceptance and held stable until handshake.
- States: IDLE, RADDR, RDATA, WRITE, WRESP.
- IDLE: cmd_ready=1. On acceptance, go to RADDR (read) or WRITE (write). The corresponding VALIDs are 1 on the next cycle. cmd_ready=0 in all other states.
- RADDR: ARVALID=1 until ARVALID&&ARREADY, then ARVALID drops next cycle. Go to RDATA with RREADY=1.
- RDATA: on RVALID&&RREADY, latch RDATA/RRESP and pulse rsp_valid next cycle. RREADY drops and the block returns to IDLE.
- WRITE: AWVALID and WVALID are asserted together. Each drops the cycle after its own handshake, in either order or simultaneously. When both handshakes are done, go to WRESP with BREADY=1.
- WRESP: on BVALID&&BREADY, latch BRESP, pulse rsp_valid with rsp_write=1, return to IDLE.
- VALID is never withdrawn before its handshake, including on timeout.
- Watchdog: runs only in RDATA and WRESP. The counter clears on entry and increments each cycle without handshake. When it reaches TIMEOUT_CYCLES-1, drop READY, pulse rsp_valid with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, and return to IDLE.
- Handshake on the same cycle as expiry: the handshake wins and completion is normal.
- Best-case latency, slave always ready: read rsp_valid 3 cycles after acceptance; write rsp_valid 3 cycles after acceptance.
- rsp_* fields hold their last value between pulses. Only rsp_valid is a pulse.
- cmd_valid while busy is ignored; no queueing.

Decomposition:
- Shared package axi4_lite_pkg: state encoding localparams, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, default widths.
- One natural sub-module, axi4_lite_timeout_ctr: clear/enable/expire counter parametrised by TIMEOUT_CYCLES and TO_WIDTH.

Test Plan:
- Read, slave always ready, RDATA=0xDEADBEEF, RRESP=0: ARVALID on cycle 1, rsp_valid on cycle 3, rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_timeout=0.
- Write addr 0x10, data 0x12345678, strobe 4'b0011; AWREADY delayed 3 cycles, WREADY immediate: WVALID drops after 1 cycle, AWVALID holds 3 cycles, BREADY only after both handshakes, WSTRB=0011 seen at the slave.
- Write with WREADY before AWREADY, then BRESP=2'b11: rsp_valid with rsp_write=1, rsp_resp=3.
- Read with RVALID never asserted, TIMEOUT_CYCLES=8: RREADY drops, rsp_valid with rsp_timeout=1, rsp_resp=2, back in IDLE with cmd_ready=1.
- RVALID asserted on the exact expiry cycle: normal completion, rsp_timeout=0, data captured.
- ARESETN pulsed low during WRESP: all outputs 0 next cycle, no rsp_valid, a new read then completes normally.
